beat_counter_mod: RTL
=====================

Name: beat_counter_mod

Overview:
- Beat-gated, programmable-modulus counter for the timing and sequencing fabric.
- Successor to the fixed-modulus up-counter. Adds:
  - runtime modulus
  - up/down direction
  - wrap, saturate and one-shot modes
  - parallel load and synchronous clear
  - a registered terminal-count pulse
- Drives tempo and step sequencers and cascades into further counters through tc.

Parameters:
WIDTH, 8, counter and modulus width in bits.
RESET_MAX, 255, value max_val should hold after reset; informational only, never used in logic.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high; highest priority
beat  in  1  step qualifier, one-cycle pulse per tick
enable  in  1  step gate; a step requires enable & beat
up  in  1  1 = count up, 0 = count down; sampled per step
mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
max_val  in  WIDTH  terminal value for up counting, wrap target for down counting
start  in  1  one-shot arm; ignored in other modes
load  in  1  parallel load request
load_val  in  WIDTH  value to load
clear  in  1  synchronous clear
count  out  WIDTH  current count (register output)
tc  out  1  registered one-cycle terminal-count pulse
running  out  1  one-shot FSM in RUN
done  out  1  one-shot FSM in DONE

Behaviour:
- Reset: count=0, tc=0, FSM=IDLE (running=0, done=0). Reset mid-operation discards everything, including a pending load or start.
- Priority per cycle: reset > clear > load > start > step.
  - clear: count=0, tc=0, FSM→IDLE.
  - load: count=min(load_val, max_val), tc=0; FSM unchanged.
- Step: taken when enable & beat and either (mode≠10) or (FSM=RUN). No step means count holds and tc=0 next cycle.
- Terminal value T: max_val when up=1, 0 when up=0.
- Up step:
  - count<max_val: count+1.
  - count≥max_val (terminal, or above after max_val was lowered): wrap mode → 0 with tc; saturate and one-shot → max_val, no further movement.
- Down step:
  - count>max_val: clamp to max_val, no tc.
  - 0<count≤max_val: count−1.
  - count=0: wrap mode → max_val with tc; saturate and one-shot → hold at 0.
- tc rules:
  - tc=1 in the cycle after a qualifying step, i.e. coincident with the new count.
  - Wrap mode: qualifying step is the wrapping step.
  - Saturate and one-shot: qualifying step is the one whose result first equals T. Steps blocked at T give tc=0.
  - tc is never high two consecutive cycles unless two consecutive qualifying steps occur. Only possible when max_val=0 in wrap mode: a wrap on every beat.
- One-shot FSM:
  - IDLE --start--> RUN. count is not modified by start; load it beforehand if needed.
  - RUN --step producing T--> DONE, with tc.
  - DONE --start--> RUN. This only restarts usefully after a load or clear.
  - Any state --clear/reset--> IDLE.
  - start while in RUN is ignored.
  - Mode change away from 10 forces FSM→IDLE next cycle.
- max_val=0:
  - Wrap mode: every step gives tc, count stays 0.
  - Saturate: count stays 0, tc only if count was nonzero before the step.
- Width: arithmetic is modulo 2^WIDTH internally, but the result never escapes [0, max_val] except via reset-time values. No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, mode=00, up=1, max_val=4, enable=1, beat every 2 cycles → count 0,1,2,3,4,0; tc single pulse with count=0 after the 5th beat.
- mode=01, up=0, load_val=3, load, then 5 beats → count 3,2,1,0,0,0; one tc pulse when reaching 0; beats with enable=0 leave count unchanged.
- mode=10, load 0, max_val=2, start, 4 beats → running 1 for beats 1–2, count 1,2, tc with count=2, done=1, count holds; 2nd start then clear → IDLE, count=0.
- Simultaneous: load=1, clear=1, beat=1 in the same cycle → count=0; load=1, beat=1 with load_val=9, max_val=6 → count=6 (clamped, no step).
- mode=00, count=7, max_val lowered to 5, up step → count=0 with tc; down step from 7 → count=5, no tc.
- Reset asserted during RUN with count=3 and a pending beat → next cycle count=0, tc=0, running=0, done=0; a beat on the reset-release cycle is counted normally.

Source files
------------

// File: rtl/beat_counter_mod.sv
// beat_counter_mod: beat-gated programmable-modulus counter with wrap/saturate/one-shot modes
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - synchronous active-high reset, highest priority
//   beat     - one-cycle step qualifier
//   enable   - step gate; a step needs enable & beat
//   up       - 1 count up, 0 count down
//   mode     - 00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   max_val  - terminal value going up, wrap target going down
//   start    - one-shot arm (one-shot mode only)
//   load     - parallel load request
//   load_val - value to load, clamped to max_val
//   clear    - synchronous clear
//   count    - current count
//   tc       - registered one-cycle terminal-count pulse
//   running  - one-shot FSM in RUN
//   done     - one-shot FSM in DONE
module beat_counter_mod #(
    parameter int WIDTH     = 8,
    parameter int RESET_MAX = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             beat,
    input  logic             enable,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] max_val,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             running,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // RESET_MAX documents the expected post-reset max_val; it drives no logic.
    if (RESET_MAX < 0) begin : g_reset_max_info
    end

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;

    logic             w_wrap;
    logic             w_oneshot;
    logic             w_step;
    logic             w_start;
    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_up_next;
    logic [WIDTH-1:0] w_dn_next;
    logic [WIDTH-1:0] w_next;
    logic             w_tc;
    logic [WIDTH-1:0] w_load_clamped;

    always_comb begin
        w_wrap         = ~mode[0] ^ mode[1] ? 1'b1 : 1'b0;
        w_oneshot      = mode == 2'b10;
        w_step         = enable & beat & (~w_oneshot | (r_state == S_RUN));
        // start only wins over a step when it actually arms the FSM
        w_start        = start & w_oneshot & (r_state != S_RUN);
        w_term         = up ? max_val : '0;
        // at or above max_val (max_val may have been lowered) the up step wraps or pins
        w_up_next      = (r_count < max_val) ? r_count + 1'b1 : (w_wrap ? '0 : max_val);
        // above max_val a down step clamps first; at 0 it wraps or holds
        w_dn_next      = (r_count > max_val) ? max_val :
                         (r_count != '0) ? r_count - 1'b1 : (w_wrap ? max_val : '0);
        w_next         = up ? w_up_next : w_dn_next;
        // wrap mode flags the wrapping step; others flag first arrival at the terminal
        w_tc           = w_wrap ? (up ? (r_count >= max_val) : (r_count == '0)) :
                         ((w_next == w_term) && (r_count != w_term));
        w_load_clamped = (load_val > max_val) ? max_val : load_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (!w_oneshot)
                r_state <= S_IDLE;
            if (load) begin
                r_count <= w_load_clamped;
            end else if (w_start) begin
                r_state <= S_RUN;
            end else if (w_step) begin
                r_count <= w_next;
                r_tc    <= w_tc;
                if (w_oneshot && (w_next == w_term))
                    r_state <= S_DONE;
            end
        end
    end

    assign count   = r_count;
    assign tc      = r_tc;
    assign running = r_state == S_RUN;
    assign done    = r_state == S_DONE;

endmodule
